// File: rtl/rr_sel_if.sv
// Request/grant bundle between the requesters, the consumer and the round-robin arbiter.
interface rr_sel_if #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned IDX_W = 3
);
  logic [WIDTH-1:0] req;
  logic             ack;
  logic [WIDTH-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             timeout;

  // Arbiter side drives the grant/sel outputs.
  modport master (
    input  req,
    input  ack,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );

  // Requester/consumer side.
  modport slave (
    output req,
    output ack,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );
endinterface

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter producing a registered one-hot mux select, held until ack,
// with a hold timeout that force-releases a stalled grant.
module rr_sel_arbiter #(
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  rr_sel_if.master  bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 32'd0) ? 32'd0 : MAX_HOLD - 32'd1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH - 32'd1);
  localparam bit               HOLD_EN   = (MAX_HOLD != 32'd0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [IDX_W-1:0] nxt_ptr_c;
  logic             idle_hit_c;
  logic [IDX_W-1:0] idle_idx_c;
  logic             ack_hit_c;
  logic [IDX_W-1:0] ack_idx_c;

  // Circular first-set search from base; iterating downward lets the lowest offset win.
  function automatic logic [IDX_W:0] pick(input logic [WIDTH-1:0] r,
                                          input logic [IDX_W-1:0] base);
    logic [IDX_W:0] res;
    int unsigned    cand;
    res = '0;
    for (int unsigned k = WIDTH; k > 0; k--) begin
      cand = 32'(base) + k - 32'd1;
      if (cand >= WIDTH) cand = cand - WIDTH;
      if (r[cand[IDX_W-1:0]]) res = {1'b1, cand[IDX_W-1:0]};
    end
    return res;
  endfunction

  // Two lookups: from ptr when idle, and from the post-service pointer for back-to-back grants.
  always_comb begin
    nxt_ptr_c                = (bus.grant_idx == LAST_IDX) ? '0 : bus.grant_idx + 1'b1;
    {idle_hit_c, idle_idx_c} = pick(bus.req, ptr);
    {ack_hit_c,  ack_idx_c}  = pick(bus.req, nxt_ptr_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      ptr             <= '0;
      hold_cnt        <= '0;
      bus.grant       <= '0;
      bus.grant_idx   <= '0;
      bus.grant_valid <= 1'b0;
      bus.timeout     <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (idle_hit_c) begin
            bus.grant       <= WIDTH'(1) << idle_idx_c;
            bus.grant_idx   <= idle_idx_c;
            bus.grant_valid <= 1'b1;
            hold_cnt        <= '0;
            state           <= BUSY;
          end
        end
        BUSY: begin
          if (bus.ack) begin
            ptr      <= nxt_ptr_c;
            hold_cnt <= '0;
            if (ack_hit_c) begin
              bus.grant     <= WIDTH'(1) << ack_idx_c;
              bus.grant_idx <= ack_idx_c;
            end else begin
              bus.grant       <= '0;
              bus.grant_idx   <= '0;
              bus.grant_valid <= 1'b0;
              state           <= IDLE;
            end
          end else if (HOLD_EN) begin
            // Forced release leaves one idle cycle; no re-grant on this edge.
            if (hold_cnt == HOLD_LAST) begin
              bus.timeout     <= 1'b1;
              ptr             <= nxt_ptr_c;
              hold_cnt        <= '0;
              bus.grant       <= '0;
              bus.grant_idx   <= '0;
              bus.grant_valid <= 1'b0;
              state           <= IDLE;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed and randomized checks for rr_sel_arbiter with hand-computed expectations.
module tb_rr_sel_arbiter;
  localparam int unsigned WIDTH = 6;
  localparam int unsigned IDX_W = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  rr_sel_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  rr_sel_arbiter #(.WIDTH(WIDTH), .IDX_W(IDX_W), .MAX_HOLD(15), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [WIDTH-1:0] g, input logic [IDX_W-1:0] idx,
                         input logic v, input logic to);
    chk({tag, ".grant"},       32'(bus.grant),       32'(g));
    chk({tag, ".grant_idx"},   32'(bus.grant_idx),   32'(idx));
    chk({tag, ".grant_valid"}, 32'(bus.grant_valid), 32'(v));
    chk({tag, ".timeout"},     32'(bus.timeout),     32'(to));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]       dat [WIDTH];
  logic [7:0]       mux_out;
  logic [WIDTH-1:0] prev_grant;
  logic             prev_valid;
  logic             prev_ack;
  logic [IDX_W-1:0] exp_idx;

  initial begin
    rst_n = 1'b0;
    bus.req = 6'b111111;
    bus.ack = 1'b0;

    // Reset held with all requests active
    repeat (3) step();
    chk_out("reset", 6'b0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    bus.req = 6'b0;
    step();
    chk_out("idle_after_reset", 6'b0, 3'd0, 1'b0, 1'b0);

    // Single grant, latency, hold without ack
    bus.req = 6'b000100;
    step();
    chk_out("single_grant", 6'b000100, 3'd2, 1'b1, 1'b0);
    bus.req = 6'b0;
    step();
    step();
    chk_out("hold_after_req_drop", 6'b000100, 3'd2, 1'b1, 1'b0);
    bus.ack = 1'b1;
    step();
    chk_out("release_on_ack", 6'b0, 3'd0, 1'b0, 1'b0);
    bus.ack = 1'b0;
    bus.req = 6'b001101;              // ptr=3: bit 3 beats bits 0 and 2
    step();
    chk_out("search_from_3", 6'b001000, 3'd3, 1'b1, 1'b0);
    bus.req = 6'b0;
    bus.ack = 1'b1;
    step();
    chk_out("release2", 6'b0, 3'd0, 1'b0, 1'b0);
    bus.ack = 1'b0;

    // Rotation from ptr=0 after a fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.req = 6'b111111;
    step();
    chk_out("rot0", 6'b000001, 3'd0, 1'b1, 1'b0);
    bus.ack = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      exp_idx = IDX_W'(i % 6);
      step();
      chk_out("rotation", WIDTH'(1) << exp_idx, exp_idx, 1'b1, 1'b0);
    end
    bus.req = 6'b0;
    step();                           // served 0 -> ptr=1
    chk_out("rot_end", 6'b0, 3'd0, 1'b0, 1'b0);
    bus.ack = 1'b0;

    // Wrap and skip: serve 4 so ptr=5, then bits 0/1 only
    bus.req = 6'b010000;
    step();
    chk_out("serve4", 6'b010000, 3'd4, 1'b1, 1'b0);
    bus.req = 6'b0;
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    bus.req = 6'b000011;
    step();
    chk_out("wrap_to_0", 6'b000001, 3'd0, 1'b1, 1'b0);
    bus.ack = 1'b1;
    step();
    chk_out("wrap_b2b_1", 6'b000010, 3'd1, 1'b1, 1'b0);
    bus.req = 6'b0;
    step();                           // ptr=2
    chk_out("wrap_end", 6'b0, 3'd0, 1'b0, 1'b0);
    bus.ack = 1'b0;

    // Timeout after 15 held cycles
    bus.req = 6'b010000;
    step();
    chk_out("to_grant", 6'b010000, 3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) begin
      step();
      chk_out("to_hold", 6'b010000, 3'd4, 1'b1, 1'b0);
    end
    bus.req = 6'b010001;
    step();
    chk_out("to_pulse", 6'b0, 3'd0, 1'b0, 1'b1);
    step();                           // ptr=5: bit 0 wins over bit 4
    chk_out("to_regrant_ptr5", 6'b000001, 3'd0, 1'b1, 1'b0);
    bus.req = 6'b010000;
    bus.ack = 1'b1;
    step();
    chk_out("to2_grant", 6'b010000, 3'd4, 1'b1, 1'b0);
    bus.ack = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      chk_out("to2_hold", 6'b010000, 3'd4, 1'b1, 1'b0);
    end
    bus.req = 6'b0;
    bus.ack = 1'b1;
    step();
    chk_out("ack_beats_timeout", 6'b0, 3'd0, 1'b0, 1'b0);
    bus.ack = 1'b0;

    // Mid-grant reset ignores ack
    bus.req = 6'b000001;
    step();
    chk_out("pre_reset_grant", 6'b000001, 3'd0, 1'b1, 1'b0);
    rst_n = 1'b0;
    bus.ack = 1'b1;
    bus.req = 6'b111111;
    step();
    chk_out("mid_grant_reset", 6'b0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    bus.ack = 1'b0;
    bus.req = 6'b0;
    step();

    // Randomized invariants and mux model
    for (int n = 0; n < 5000; n++) begin
      prev_grant = bus.grant;
      prev_valid = bus.grant_valid;
      bus.req = WIDTH'($urandom & $urandom & $urandom);
      bus.ack = 1'($urandom_range(0, 1));
      prev_ack = bus.ack;
      for (int d = 0; d < WIDTH; d++) dat[d] = 8'($urandom);
      step();
      chk("rnd.onehot0", 32'($onehot0(bus.grant)), 32'd1);
      chk("rnd.valid", 32'(bus.grant_valid), 32'(|bus.grant));
      if (bus.grant_valid) begin
        chk("rnd.idx", 32'(bus.grant), 32'(WIDTH'(1) << bus.grant_idx));
        mux_out = '0;
        for (int d = 0; d < WIDTH; d++) if (bus.grant[d]) mux_out = mux_out | dat[d];
        chk("rnd.mux", 32'(mux_out), 32'(dat[bus.grant_idx]));
        if (prev_valid && !prev_ack) chk("rnd.stable", 32'(bus.grant), 32'(prev_grant));
      end else begin
        chk("rnd.idle_idx", 32'(bus.grant_idx), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rr_sel_arbiter.md
Name: rr_sel_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the priority mux.
- Takes WIDTH request lines and drives a registered one-hot grant vector, which is used as the mux sel, so the mux's sparse-select case reduces to exactly one bit set.
- Holds each grant until the downstream consumer acknowledges the transfer.
- Rotates priority for fairness and enforces a hold timeout so a stuck consumer cannot lock the mux.

Parameters:
- WIDTH, 6, number of requesters and width of the grant/sel vector.
- IDX_W, 3, width of the binary grant index; must satisfy 2**IDX_W >= WIDTH.
- MAX_HOLD, 15, maximum cycles a grant is held without ack before forced release; 0 disables the timeout.
- CNT_W, 4, width of the hold counter; must hold MAX_HOLD.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req  in  WIDTH  request vector; bit i high means requester i wants the mux.
- ack  in  1  consumer accepted the currently granted data; only meaningful while grant_valid=1.
- grant  out  WIDTH  registered one-hot grant; feeds the mux sel. All zero when idle.
- grant_idx  out  IDX_W  binary index of the set grant bit; 0 when idle.
- grant_valid  out  1  high when grant is non-zero.
- timeout  out  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - Rotation pointer ptr=0, hold counter=0, state IDLE.
  - Reset asserted mid-grant clears everything on that edge; ack in the same cycle is ignored.
- Selection function:
  - Search req circularly in ascending index order, starting at ptr and wrapping from WIDTH-1 to 0.
  - The first set bit wins. Pure combinational lookup; its result is registered only.
- State IDLE (grant_valid=0):
  - If |req at an edge: load grant/grant_idx from the selection, set grant_valid=1, clear the counter, go to BUSY.
  - Latency: req sampled at edge N, grant visible after edge N (1 cycle).
  - If req=0, stay in IDLE.
  - ack is ignored in IDLE.
- State BUSY (grant_valid=1):
  - grant and grant_idx are held stable regardless of req changes, including the granted requester dropping req.
  - ack=1 at an edge:
    - Set ptr to (grant_idx+1) mod WIDTH.
    - If |req, re-arbitrate this same edge using the new ptr, giving back-to-back grants with no bubble. The just-served requester has lowest priority.
    - Otherwise grant=0 and go to IDLE.
    - Counter clears.
  - ack=0 with MAX_HOLD!=0: counter increments.
    - Timeout fires at the edge where counter == MAX_HOLD-1, i.e. after the grant has been held MAX_HOLD cycles.
    - On timeout: timeout pulses high for one cycle, ptr advances as for ack, and grant is dropped to 0 with state IDLE. There is no immediate re-grant, so there is always one idle cycle after a timeout.
  - ack and the timeout condition on the same edge: ack wins, timeout stays 0.
  - MAX_HOLD=0: the counter is frozen at 0 and never times out.
- Invariants:
  - grant is always 0 or one-hot.
  - grant_valid == |grant.
  - grant_idx matches the set bit.
  - A requester holding req continuously is granted within WIDTH grant slots.
- Wrap-around:
  - ptr wraps from WIDTH-1 to 0.
  - Non-power-of-two WIDTH never yields an index >= WIDTH.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles with req=6'b111111 -> grant=0, grant_valid=0, timeout=0. Release with req=0 -> outputs stay 0.
- Single grant and latency: req=6'b000100 at edge N -> after N, grant=6'b000100, grant_idx=2. Drop req without ack -> grant holds. ack at edge M -> grant=0 after M, next search starts at 3.
- Round-robin rotation: req=6'b111111 held, ack every cycle -> grant_idx sequence 0,1,2,3,4,5,0, back-to-back with no zero cycles between grants.
- Wrap and skip: ptr=5 (after serving 4), req=6'b000011 -> grant_idx=0; after ack, grant_idx=1.
- Timeout: MAX_HOLD=15, req=6'b010000, ack=0 -> grant held 15 cycles, timeout=1 for exactly one cycle, grant=0 for at least one cycle, ptr=5. Repeat with ack on the 15th cycle -> no timeout pulse.
- Mid-grant reset and randomized check: rst_n=0 during BUSY -> all outputs 0 on the next edge. Then run 5000 cycles of sparse random req (AND of three $random words) and random ack, checking the one-hot invariant, grant_idx consistency and grant stability while unacked each cycle. The arbiter's grant drives a priority_mux sel, and the mux output must equal dat[grant_idx] whenever grant_valid=1.
